mem_bus_arb: RTL and testbench
==============================

# mem_bus_arb

Two-requester arbiter sharing the single core memory bus between the instruction-fetch port and the MEM-stage data port (the output of the CLINT distributor). It grants one requester at a time, latches the winning request for the whole transaction, and routes the bus response back to the owner only. It sits between the pipeline's two access ports and the top-level bus interface.

## Interface
Parameters: none. Widths come from `defines.v`: `DATA_BUS` is 64 bits and `DATA_ADDR_BUS` is 64 bits.

Clock and reset:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.

Fetch port (`if`):
- arb_if_valid_i  in  1  request valid.
- arb_if_req_i  in  1  1 = write, 0 = read.
- arb_if_addr_i  in  64  byte address.
- arb_if_size_i  in  2  access size: 0 = B, 1 = H, 2 = W, 3 = D.
- arb_if_data_write_i  in  64  write data.
- arb_if_ready_o  out  1  completion pulse.
- arb_if_data_read_o  out  64  read data, meaningful only when ready is high.
- arb_if_resp_o  out  2  response code, meaningful only when ready is high.

Data port (`mem`):
- arb_mem_*  same set, directions and widths as the fetch port.

Bus side:
- arb_bus_valid_o  out  1
- arb_bus_req_o  out  1
- arb_bus_addr_o  out  64
- arb_bus_size_o  out  2
- arb_bus_data_write_o  out  64
- arb_bus_ready_i  in  1
- arb_bus_data_read_i  in  64
- arb_bus_resp_i  in  2

Status:
- arb_busy_o  out  1  high while the FSM is not IDLE.

## Operation
State machine with three states: IDLE, GNT_IF, GNT_MEM.

- **IDLE**
  - No valid request: stay in IDLE.
  - One requester valid: grant it and go to GNT_IF or GNT_MEM.
  - Both valid: the winner is chosen per the Configuration section.
  - On every grant, capture {req, addr, size, data_write} from the winner into the request register.
- **GNT_x**
  - arb_bus_valid_o = 1 and all bus outputs are driven from the request register.
  - Later changes on the owner's inputs are ignored.
- **Completion** (arb_bus_ready_i = 1 while in GNT_x):
  - arb_x_ready_o = arb_x_valid_i, so a request the owner has abandoned is dropped silently.
  - arb_x_data_read_o = arb_bus_data_read_i and arb_x_resp_o = arb_bus_resp_i, same cycle (combinational).
  - Next state:
    - The other requester is valid in the completion cycle: go directly to GNT_other, capture its request, no bubble.
    - Otherwise: go to IDLE.
- The non-owner's ready is always 0. Its data_read and resp outputs are 0.
- A requester must hold valid and its fields stable until its ready pulse. It may drop valid early only for a pipeline flush.
- Last-grant register (`last_gnt`): 0 = IF, 1 = MEM. It is updated on every grant.

## Timing
- Reset values:
  - state = IDLE, last_gnt = 1, request register = 0.
  - All outputs = 0, including arb_bus_valid_o, both ready outputs and arb_busy_o.
- Arbitration latency: valid seen in IDLE in cycle N → arb_bus_valid_o = 1 in cycle N+1.
- Bus valid stays high until the cycle where arb_bus_ready_i = 1. It falls in the next cycle unless a back-to-back grant keeps it high with new fields.
- A ready at the bus completes in the same cycle at the owner port. Minimum owner-visible latency is 2 cycles (zero-wait bus).
- arb_bus_ready_i while in IDLE is ignored.
- Reset asserted mid-transaction: next cycle is IDLE with bus valid 0. No ready is produced for the aborted request. The downstream bridge is reset by the same rst.

## Configuration
Macro: `MEM_BUS_ARB_RR_EN` selects how a tie in IDLE is resolved.

- **Undefined:** fixed priority, MEM over IF. The older instruction's data access always wins a tie.
- **Defined:** round-robin. On a tie, the requester not recorded in last_gnt wins. The back-to-back hand-over at completion already alternates in both modes.

## Test plan
- **Single read.** Reset, then IF read at addr 0x80000000, size 3. Bus ready after 3 cycles with data 0x1122334455667788, resp 0.
  - arb_if_ready_o pulses once, in the bus-ready cycle, with that data.
  - MEM outputs stay 0.
- **Tie, fixed priority** (macro undefined). IF and MEM both valid in cycle N; MEM write of 0xDEADBEEF to 0x80001000, size 2.
  - Bus carries the MEM write from cycle N+1.
  - After its ready, the IF request follows with no IDLE cycle in between.
- **Round-robin** (`MEM_BUS_ARB_RR_EN` defined). Both ports valid continuously for 6 transactions with zero-wait ready.
  - Grants are IF, MEM, IF, MEM, IF, MEM.
  - The first grant is IF because last_gnt = 1 after reset.
- **Field latching.** Change arb_mem_addr_i to 0x0 while granted and waiting on ready.
  - arb_bus_addr_o holds the originally captured address until ready.
- **Flush.** Owner drops valid before the bus ready.
  - The bus transaction still completes.
  - The owner's ready stays 0.
  - The FSM returns to IDLE.
- **Reset mid-transaction.** Assert rst during GNT_IF.
  - Next cycle: state IDLE, arb_bus_valid_o = 0, arb_busy_o = 0, no ready pulse.

Source files
------------

// File: rtl/mem_bus_arb_if.sv
// rtl/mem_bus_arb_if.sv - signal bundle for the fetch port, data port and bus side of mem_bus_arb
// slave modport : arbiter view (requests and bus response in; completions and bus request out).
// master modport: surrounding pipeline/bus view (directions reversed).
// All widths are 64-bit data/address, 2-bit size and response.
interface mem_bus_arb_if;
   // fetch port
   logic        arb_if_valid_i;
   logic        arb_if_req_i;
   logic [63:0] arb_if_addr_i;
   logic [1:0]  arb_if_size_i;
   logic [63:0] arb_if_data_write_i;
   logic        arb_if_ready_o;
   logic [63:0] arb_if_data_read_o;
   logic [1:0]  arb_if_resp_o;
   // data port
   logic        arb_mem_valid_i;
   logic        arb_mem_req_i;
   logic [63:0] arb_mem_addr_i;
   logic [1:0]  arb_mem_size_i;
   logic [63:0] arb_mem_data_write_i;
   logic        arb_mem_ready_o;
   logic [63:0] arb_mem_data_read_o;
   logic [1:0]  arb_mem_resp_o;
   // bus side
   logic        arb_bus_valid_o;
   logic        arb_bus_req_o;
   logic [63:0] arb_bus_addr_o;
   logic [1:0]  arb_bus_size_o;
   logic [63:0] arb_bus_data_write_o;
   logic        arb_bus_ready_i;
   logic [63:0] arb_bus_data_read_i;
   logic [1:0]  arb_bus_resp_i;
   // status
   logic        arb_busy_o;

   modport slave (
      input  arb_if_valid_i, arb_if_req_i, arb_if_addr_i, arb_if_size_i, arb_if_data_write_i,
      output arb_if_ready_o, arb_if_data_read_o, arb_if_resp_o,
      input  arb_mem_valid_i, arb_mem_req_i, arb_mem_addr_i, arb_mem_size_i, arb_mem_data_write_i,
      output arb_mem_ready_o, arb_mem_data_read_o, arb_mem_resp_o,
      output arb_bus_valid_o, arb_bus_req_o, arb_bus_addr_o, arb_bus_size_o, arb_bus_data_write_o,
      input  arb_bus_ready_i, arb_bus_data_read_i, arb_bus_resp_i,
      output arb_busy_o
   );

   modport master (
      output arb_if_valid_i, arb_if_req_i, arb_if_addr_i, arb_if_size_i, arb_if_data_write_i,
      input  arb_if_ready_o, arb_if_data_read_o, arb_if_resp_o,
      output arb_mem_valid_i, arb_mem_req_i, arb_mem_addr_i, arb_mem_size_i, arb_mem_data_write_i,
      input  arb_mem_ready_o, arb_mem_data_read_o, arb_mem_resp_o,
      input  arb_bus_valid_o, arb_bus_req_o, arb_bus_addr_o, arb_bus_size_o, arb_bus_data_write_o,
      output arb_bus_ready_i, arb_bus_data_read_i, arb_bus_resp_i,
      input  arb_busy_o
   );
endinterface

// File: rtl/mem_bus_arb.sv
// rtl/mem_bus_arb.sv - two-requester arbiter sharing the core memory bus between fetch and data ports
// Ports: clk (rising edge), rst (synchronous, active-high);
//   arb (mem_bus_arb_if.slave): fetch port arb_if_*, data port arb_mem_*, bus side arb_bus_*, arb_busy_o.
// Build option MEM_BUS_ARB_RR_EN: defined = round-robin tie-break in IDLE,
//   undefined = fixed priority, MEM over IF.
module mem_bus_arb (
   input  logic         clk,
   input  logic         rst,
   mem_bus_arb_if.slave arb
);
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GNT_IF  = 2'd1,
      GNT_MEM = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        last_gnt_q;      // 0 = IF won last grant, 1 = MEM
   logic        req_q;
   logic [63:0] addr_q;
   logic [1:0]  size_q;
   logic [63:0] wdata_q;

   logic        grant_if, grant_mem;
   logic        tie_to_if;
   logic        busy;
   logic        if_rdy, mem_rdy;

`ifdef MEM_BUS_ARB_RR_EN
   // MEM took the last grant -> IF's turn on a tie
   assign tie_to_if = last_gnt_q;
`else
   // the older instruction's data access always wins; last_gnt is tracked but not consulted
   assign tie_to_if = 1'b0 & last_gnt_q;
`endif

   always_comb begin
      state_d   = state_q;
      grant_if  = 1'b0;
      grant_mem = 1'b0;
      case (state_q)
         IDLE: begin
            if (arb.arb_if_valid_i && arb.arb_mem_valid_i) begin
               grant_if  = tie_to_if;
               grant_mem = !tie_to_if;
            end else begin
               grant_if  = arb.arb_if_valid_i;
               grant_mem = arb.arb_mem_valid_i;
            end
         end
         GNT_IF: begin
            // completion hands the bus straight to a waiting data port, no bubble
            if (arb.arb_bus_ready_i) begin
               state_d   = IDLE;
               grant_mem = arb.arb_mem_valid_i;
            end
         end
         GNT_MEM: begin
            if (arb.arb_bus_ready_i) begin
               state_d  = IDLE;
               grant_if = arb.arb_if_valid_i;
            end
         end
         default: state_d = IDLE;
      endcase
      if (grant_if) begin
         state_d = GNT_IF;
      end else if (grant_mem) begin
         state_d = GNT_MEM;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         last_gnt_q <= 1'b1;
         req_q      <= 1'b0;
         addr_q     <= '0;
         size_q     <= '0;
         wdata_q    <= '0;
      end else begin
         state_q <= state_d;
         if (grant_if) begin
            req_q      <= arb.arb_if_req_i;
            addr_q     <= arb.arb_if_addr_i;
            size_q     <= arb.arb_if_size_i;
            wdata_q    <= arb.arb_if_data_write_i;
            last_gnt_q <= 1'b0;
         end else if (grant_mem) begin
            req_q      <= arb.arb_mem_req_i;
            addr_q     <= arb.arb_mem_addr_i;
            size_q     <= arb.arb_mem_size_i;
            wdata_q    <= arb.arb_mem_data_write_i;
            last_gnt_q <= 1'b1;
         end
      end
   end

   assign busy = (state_q != IDLE);

   // bus fields come only from the request register, so owner-side changes after grant are ignored
   assign arb.arb_busy_o           = busy;
   assign arb.arb_bus_valid_o      = busy;
   assign arb.arb_bus_req_o        = busy & req_q;
   assign arb.arb_bus_addr_o       = busy ? addr_q  : '0;
   assign arb.arb_bus_size_o       = busy ? size_q  : '0;
   assign arb.arb_bus_data_write_o = busy ? wdata_q : '0;

   // a flushed owner (valid dropped) gets no ready; the bus beat still retires the transaction
   assign if_rdy  = (state_q == GNT_IF)  & arb.arb_bus_ready_i & arb.arb_if_valid_i;
   assign mem_rdy = (state_q == GNT_MEM) & arb.arb_bus_ready_i & arb.arb_mem_valid_i;

   assign arb.arb_if_ready_o      = if_rdy;
   assign arb.arb_if_data_read_o  = if_rdy ? arb.arb_bus_data_read_i : '0;
   assign arb.arb_if_resp_o       = if_rdy ? arb.arb_bus_resp_i      : '0;
   assign arb.arb_mem_ready_o     = mem_rdy;
   assign arb.arb_mem_data_read_o = mem_rdy ? arb.arb_bus_data_read_i : '0;
   assign arb.arb_mem_resp_o      = mem_rdy ? arb.arb_bus_resp_i      : '0;
endmodule

// File: tb/tb_mem_bus_arb.sv
// tb/tb_mem_bus_arb.sv - self-checking bench for mem_bus_arb
module tb_mem_bus_arb;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_bus_arb_if arb_sig ();

   mem_bus_arb dut (
      .clk (clk),
      .rst (rst),
      .arb (arb_sig)
   );

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;
   int grants[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // owner: 0 = nobody holds the bus, 1 = fetch port, 2 = data port
   int          m_owner = 0;
   bit          m_last  = 1'b1;
   logic        m_req   = 1'b0;
   logic [63:0] m_addr  = '0;
   logic [1:0]  m_size  = '0;
   logic [63:0] m_wdata = '0;

   function automatic bit port_valid(input int who);
      return (who == 1) ? arb_sig.arb_if_valid_i : arb_sig.arb_mem_valid_i;
   endfunction

   always @(posedge clk) begin : model
      int nxt;
      if (rst) begin
         m_owner <= 0;
         m_last  <= 1'b1;
         m_req   <= 1'b0;
         m_addr  <= '0;
         m_size  <= '0;
         m_wdata <= '0;
      end else begin
         nxt = m_owner;
         if (m_owner == 0) begin
            if (port_valid(1) && port_valid(2)) begin
`ifdef MEM_BUS_ARB_RR_EN
               nxt = m_last ? 1 : 2;
`else
               nxt = 2;
`endif
            end else if (port_valid(1)) nxt = 1;
            else if (port_valid(2)) nxt = 2;
         end else if (arb_sig.arb_bus_ready_i) begin
            nxt = port_valid(3 - m_owner) ? (3 - m_owner) : 0;
         end
         if (nxt == 1 && m_owner != 1) begin
            m_req <= arb_sig.arb_if_req_i;   m_addr  <= arb_sig.arb_if_addr_i;
            m_size <= arb_sig.arb_if_size_i; m_wdata <= arb_sig.arb_if_data_write_i;
            m_last <= 1'b0;
         end else if (nxt == 2 && m_owner != 2) begin
            m_req <= arb_sig.arb_mem_req_i;   m_addr  <= arb_sig.arb_mem_addr_i;
            m_size <= arb_sig.arb_mem_size_i; m_wdata <= arb_sig.arb_mem_data_write_i;
            m_last <= 1'b1;
         end
         m_owner <= nxt;
      end
   end

   function automatic bit exp_ready(input int who);
      return (m_owner == who) && arb_sig.arb_bus_ready_i && port_valid(who);
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         check("m_bus_valid", 64'(arb_sig.arb_bus_valid_o), 64'(m_owner != 0));
         check("m_busy",      64'(arb_sig.arb_busy_o),      64'(m_owner != 0));
         check("m_if_ready",  64'(arb_sig.arb_if_ready_o),  64'(exp_ready(1)));
         check("m_mem_ready", 64'(arb_sig.arb_mem_ready_o), 64'(exp_ready(2)));
         if (m_owner != 0) begin
            check("m_bus_req",   64'(arb_sig.arb_bus_req_o),   64'(m_req));
            check("m_bus_addr",  arb_sig.arb_bus_addr_o,       m_addr);
            check("m_bus_size",  64'(arb_sig.arb_bus_size_o),  64'(m_size));
            check("m_bus_wdata", arb_sig.arb_bus_data_write_o, m_wdata);
         end
         if (exp_ready(1)) begin
            check("m_if_data", arb_sig.arb_if_data_read_o, arb_sig.arb_bus_data_read_i);
            check("m_if_resp", 64'(arb_sig.arb_if_resp_o), 64'(arb_sig.arb_bus_resp_i));
         end else if (m_owner != 1) begin
            check("m_if_data_zero", arb_sig.arb_if_data_read_o, 64'h0);
            check("m_if_resp_zero", 64'(arb_sig.arb_if_resp_o), 64'h0);
         end
         if (exp_ready(2)) begin
            check("m_mem_data", arb_sig.arb_mem_data_read_o, arb_sig.arb_bus_data_read_i);
            check("m_mem_resp", 64'(arb_sig.arb_mem_resp_o), 64'(arb_sig.arb_bus_resp_i));
         end else if (m_owner != 2) begin
            check("m_mem_data_zero", arb_sig.arb_mem_data_read_o, 64'h0);
            check("m_mem_resp_zero", 64'(arb_sig.arb_mem_resp_o), 64'h0);
         end
         if (arb_sig.arb_if_ready_o)  grants.push_back(1);
         if (arb_sig.arb_mem_ready_o) grants.push_back(2);
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      arb_sig.arb_if_valid_i       = 1'b0;
      arb_sig.arb_if_req_i         = 1'b0;
      arb_sig.arb_if_addr_i        = '0;
      arb_sig.arb_if_size_i        = '0;
      arb_sig.arb_if_data_write_i  = '0;
      arb_sig.arb_mem_valid_i      = 1'b0;
      arb_sig.arb_mem_req_i        = 1'b0;
      arb_sig.arb_mem_addr_i       = '0;
      arb_sig.arb_mem_size_i       = '0;
      arb_sig.arb_mem_data_write_i = '0;
      arb_sig.arb_bus_ready_i      = 1'b0;
      arb_sig.arb_bus_data_read_i  = '0;
      arb_sig.arb_bus_resp_i       = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
      grants.delete();
   endtask

   task automatic drive_if(input logic req, input logic [63:0] addr, input logic [1:0] size, input logic [63:0] wd);
      arb_sig.arb_if_valid_i = 1'b1; arb_sig.arb_if_req_i = req;
      arb_sig.arb_if_addr_i = addr;  arb_sig.arb_if_size_i = size; arb_sig.arb_if_data_write_i = wd;
   endtask

   task automatic drive_mem(input logic req, input logic [63:0] addr, input logic [1:0] size, input logic [63:0] wd);
      arb_sig.arb_mem_valid_i = 1'b1; arb_sig.arb_mem_req_i = req;
      arb_sig.arb_mem_addr_i = addr;  arb_sig.arb_mem_size_i = size; arb_sig.arb_mem_data_write_i = wd;
   endtask

   int          first_port;
   logic [63:0] first_addr, second_addr;
   int          exp_seq[6];

   initial begin
      clear_inputs();
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk_en = 1'b1;
      cyc();
      rst = 1'b0;

      // reset state
      @(negedge clk);
      check("rst_bus_valid", 64'(arb_sig.arb_bus_valid_o), 64'h0);
      check("rst_busy",      64'(arb_sig.arb_busy_o),      64'h0);
      check("rst_if_ready",  64'(arb_sig.arb_if_ready_o),  64'h0);
      check("rst_mem_ready", 64'(arb_sig.arb_mem_ready_o), 64'h0);
      check("rst_bus_addr",  arb_sig.arb_bus_addr_o,       64'h0);

      // single read with a 3-cycle bus
      cyc();
      grants.delete();
      drive_if(1'b0, 64'h0000_0000_8000_0000, 2'd3, 64'h0);
      @(negedge clk);
      check("t1_valid_n", 64'(arb_sig.arb_bus_valid_o), 64'h0);
      cyc();
      @(negedge clk);
      check("t1_valid_n1", 64'(arb_sig.arb_bus_valid_o), 64'h1);
      check("t1_addr",     arb_sig.arb_bus_addr_o,       64'h0000_0000_8000_0000);
      check("t1_size",     64'(arb_sig.arb_bus_size_o),  64'h3);
      cyc();
      cyc();
      arb_sig.arb_bus_ready_i     = 1'b1;
      arb_sig.arb_bus_data_read_i = 64'h1122_3344_5566_7788;
      arb_sig.arb_bus_resp_i      = 2'd0;
      @(negedge clk);
      check("t1_if_ready", 64'(arb_sig.arb_if_ready_o), 64'h1);
      check("t1_if_data",  arb_sig.arb_if_data_read_o,  64'h1122_3344_5566_7788);
      check("t1_mem_data", arb_sig.arb_mem_data_read_o, 64'h0);
      cyc();
      clear_inputs();
      @(negedge clk);
      check("t1_busy_after", 64'(arb_sig.arb_busy_o), 64'h0);
      check("t1_pulses",     64'(grants.size()),       64'h1);

      // tie in IDLE, then back-to-back hand-over
      do_reset();
`ifdef MEM_BUS_ARB_RR_EN
      first_port = 1; first_addr = 64'h8000_0040; second_addr = 64'h8000_1000;
`else
      first_port = 2; first_addr = 64'h8000_1000; second_addr = 64'h8000_0040;
`endif
      drive_if(1'b0, 64'h8000_0040, 2'd2, 64'h0);
      drive_mem(1'b1, 64'h8000_1000, 2'd2, 64'h0000_0000_DEAD_BEEF);
      cyc();
      arb_sig.arb_bus_ready_i = 1'b1;
      @(negedge clk);
      check("t2_first_addr", arb_sig.arb_bus_addr_o, first_addr);
      check("t2_first_rdy",  64'((first_port == 1) ? arb_sig.arb_if_ready_o : arb_sig.arb_mem_ready_o), 64'h1);
`ifndef MEM_BUS_ARB_RR_EN
      check("t2_mem_write", 64'(arb_sig.arb_bus_req_o), 64'h1);
      check("t2_mem_wdata", arb_sig.arb_bus_data_write_o, 64'h0000_0000_DEAD_BEEF);
`endif
      cyc();
      if (first_port == 1) arb_sig.arb_if_valid_i = 1'b0;
      else arb_sig.arb_mem_valid_i = 1'b0;
      arb_sig.arb_bus_ready_i = 1'b0;
      @(negedge clk);
      check("t2_no_bubble", 64'(arb_sig.arb_bus_valid_o), 64'h1);
      check("t2_second_addr", arb_sig.arb_bus_addr_o, second_addr);
      cyc();
      arb_sig.arb_bus_ready_i = 1'b1;
      @(negedge clk);
      check("t2_second_rdy", 64'((first_port == 1) ? arb_sig.arb_mem_ready_o : arb_sig.arb_if_ready_o), 64'h1);
      cyc();
      clear_inputs();
      @(negedge clk);
      check("t2_busy_after", 64'(arb_sig.arb_busy_o), 64'h0);

      // continuous contention with a zero-wait bus
      do_reset();
`ifdef MEM_BUS_ARB_RR_EN
      exp_seq = '{1, 2, 1, 2, 1, 2};
`else
      exp_seq = '{2, 1, 2, 1, 2, 1};
`endif
      drive_if(1'b0, 64'h8000_0100, 2'd2, 64'h0);
      drive_mem(1'b0, 64'h8000_2100, 2'd3, 64'h0);
      arb_sig.arb_bus_ready_i = 1'b1;
      repeat (7) cyc();
      arb_sig.arb_if_valid_i  = 1'b0;
      arb_sig.arb_mem_valid_i = 1'b0;
      check("t3_count", 64'(grants.size()), 64'h6);
      for (int i = 0; i < 6; i++) begin
         if (i < grants.size()) check($sformatf("t3_grant%0d", i), 64'(grants[i]), 64'(exp_seq[i]));
      end
      cyc();
      clear_inputs();
      @(negedge clk);
      check("t3_idle", 64'(arb_sig.arb_busy_o), 64'h0);

      // request fields are latched at grant
      do_reset();
      drive_mem(1'b0, 64'h8000_2000, 2'd3, 64'h0);
      cyc();
      arb_sig.arb_mem_addr_i = 64'h0;
      @(negedge clk);
      check("t4_addr_held", arb_sig.arb_bus_addr_o, 64'h8000_2000);
      cyc();
      arb_sig.arb_bus_ready_i     = 1'b1;
      arb_sig.arb_bus_data_read_i = 64'hA5A5_0000_FFFF_1234;
      arb_sig.arb_bus_resp_i      = 2'd2;
      @(negedge clk);
      check("t4_addr_at_rdy", arb_sig.arb_bus_addr_o, 64'h8000_2000);
      check("t4_mem_ready",   64'(arb_sig.arb_mem_ready_o), 64'h1);
      check("t4_mem_resp",    64'(arb_sig.arb_mem_resp_o),  64'h2);
      cyc();
      clear_inputs();

      // flush: owner drops valid before the bus answers
      do_reset();
      drive_if(1'b0, 64'h8000_3000, 2'd2, 64'h0);
      cyc();
      arb_sig.arb_if_valid_i = 1'b0;
      @(negedge clk);
      check("t5_busy", 64'(arb_sig.arb_busy_o), 64'h1);
      cyc();
      arb_sig.arb_bus_ready_i = 1'b1;
      @(negedge clk);
      check("t5_no_ready", 64'(arb_sig.arb_if_ready_o), 64'h0);
      cyc();
      arb_sig.arb_bus_ready_i = 1'b0;
      @(negedge clk);
      check("t5_idle",   64'(arb_sig.arb_busy_o), 64'h0);
      check("t5_pulses", 64'(grants.size()),      64'h0);

      // reset during GNT_IF, stray bus ready afterwards is ignored
      do_reset();
      drive_if(1'b0, 64'h8000_4000, 2'd3, 64'h0);
      cyc();
      @(negedge clk);
      check("t6_granted", 64'(arb_sig.arb_busy_o), 64'h1);
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      arb_sig.arb_if_valid_i  = 1'b0;
      arb_sig.arb_bus_ready_i = 1'b1;
      @(negedge clk);
      check("t6_bus_valid", 64'(arb_sig.arb_bus_valid_o), 64'h0);
      check("t6_busy",      64'(arb_sig.arb_busy_o),      64'h0);
      check("t6_if_ready",  64'(arb_sig.arb_if_ready_o),  64'h0);
      check("t6_pulses",    64'(grants.size()),           64'h0);
      cyc();
      clear_inputs();
      cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
